// File: rtl/json_scan_pkg.sv
// json_scan_pkg: token and error encodings, scanner states and structural byte constants
package json_scan_pkg;

    typedef enum logic [2:0] {
        TOK_OBJ_BEGIN = 3'd0,
        TOK_OBJ_END   = 3'd1,
        TOK_ARR_BEGIN = 3'd2,
        TOK_ARR_END   = 3'd3,
        TOK_STR_BEGIN = 3'd4,
        TOK_STR_END   = 3'd5,
        TOK_COLON     = 3'd6,
        TOK_COMMA     = 3'd7
    } json_tok_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_OVERFLOW     = 3'd1,
        ERR_UNDERFLOW    = 3'd2,
        ERR_MISMATCH     = 3'd3,
        ERR_CTRL         = 3'd4,
        ERR_UNTERMINATED = 3'd5
    } json_scan_err_e;

    typedef enum logic [2:0] {
        ST_SCAN   = 3'd0,
        ST_STRING = 3'd1,
        ST_ESCAPE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } json_scan_state_e;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_BSLASH = 8'h5C;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/json_nest_stack.sv
// json_nest_stack: 1-bit-wide LIFO of open container kinds (0=object, 1=array)
module json_nest_stack #(
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               kind_i,
    output logic               top_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               empty_o,
    output logic               full_o
);

    logic [MAX_DEPTH-1:0] stk_q;
    logic [DEPTH_W-1:0]   depth_q;

    // Shift-register LIFO: bit 0 always holds the innermost open container
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_q   <= '0;
            depth_q <= '0;
        end else if (clear_i) begin
            stk_q   <= '0;
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            stk_q   <= MAX_DEPTH'({stk_q, kind_i});
            depth_q <= depth_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            stk_q   <= stk_q >> 1;
            depth_q <= depth_q - 1'b1;
        end
    end

    assign top_o   = stk_q[0];
    assign depth_o = depth_q;
    assign empty_o = depth_q == '0;
    assign full_o  = depth_q == DEPTH_W'(MAX_DEPTH);

endmodule

// File: rtl/json_struct_scanner.sv
// json_struct_scanner: byte-serial JSON structural tokenizer with nesting and string checks
module json_struct_scanner
    import json_scan_pkg::*;
#(
    parameter int MAX_DEPTH = 16,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2:0]         m_kind,
    output logic [DEPTH_W-1:0] m_depth,
    output logic               done,
    output logic               err,
    output logic [2:0]         err_code
);

    json_scan_state_e   state_q, state_d;
    json_scan_err_e     err_code_q, code_d;
    json_tok_e          m_kind_q, kind_d;
    logic               m_valid_q, ev_d, push_d, pop_d, is_arr, accept;
    logic               top, empty, full;
    logic [DEPTH_W-1:0] depth, depth_nxt, m_depth_q, ev_depth_d;

    assign s_ready = (state_q == ST_SCAN || state_q == ST_STRING || state_q == ST_ESCAPE)
                     && (!m_valid_q || m_ready) && !clear;
    assign accept  = s_valid && s_ready;

    json_nest_stack #(.MAX_DEPTH(MAX_DEPTH), .DEPTH_W(DEPTH_W)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (accept && push_d),
        .pop_i   (accept && pop_d),
        .kind_i  (is_arr),
        .top_o   (top),
        .depth_o (depth),
        .empty_o (empty),
        .full_o  (full)
    );

    // Classify the incoming byte: next state, token to emit, stack action and error
    always_comb begin
        state_d    = state_q;
        ev_d       = 1'b0;
        kind_d     = TOK_OBJ_BEGIN;
        ev_depth_d = depth;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        code_d     = ERR_NONE;
        is_arr     = s_data == CH_LBRACK || s_data == CH_RBRACK;
        case (state_q)
            ST_SCAN: begin
                if (s_data == CH_LBRACE || s_data == CH_LBRACK) begin
                    if (full) begin
                        code_d = ERR_OVERFLOW;
                    end else begin
                        push_d     = 1'b1;
                        ev_d       = 1'b1;
                        kind_d     = is_arr ? TOK_ARR_BEGIN : TOK_OBJ_BEGIN;
                        ev_depth_d = depth + 1'b1;
                    end
                end else if (s_data == CH_RBRACE || s_data == CH_RBRACK) begin
                    if (empty) begin
                        code_d = ERR_UNDERFLOW;
                    end else if (top != is_arr) begin
                        code_d = ERR_MISMATCH;
                    end else begin
                        pop_d  = 1'b1;
                        ev_d   = 1'b1;
                        kind_d = is_arr ? TOK_ARR_END : TOK_OBJ_END;
                    end
                end else if (s_data == CH_QUOTE) begin
                    ev_d    = 1'b1;
                    kind_d  = TOK_STR_BEGIN;
                    state_d = ST_STRING;
                end else if (s_data == CH_COLON || s_data == CH_COMMA) begin
                    ev_d   = 1'b1;
                    kind_d = (s_data == CH_COLON) ? TOK_COLON : TOK_COMMA;
                end
            end
            ST_STRING: begin
                if (s_data == CH_BSLASH) begin
                    state_d = ST_ESCAPE;
                end else if (s_data == CH_QUOTE) begin
                    ev_d    = 1'b1;
                    kind_d  = TOK_STR_END;
                    state_d = ST_SCAN;
                end else if (s_data < 8'h20) begin
                    code_d = ERR_CTRL;
                end
            end
            ST_ESCAPE: state_d = ST_STRING;
            default: ;
        endcase
        depth_nxt = push_d ? depth + 1'b1 : (pop_d ? depth - 1'b1 : depth);
        if (code_d == ERR_NONE && s_last) begin
            if (state_d == ST_SCAN && depth_nxt == '0) state_d = ST_DONE;
            else code_d = ERR_UNTERMINATED;
        end
        if (code_d != ERR_NONE) state_d = ST_ERROR;
    end

    // Scanner state, latched status and the single-entry token register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            err_code_q <= ERR_NONE;
            m_valid_q  <= 1'b0;
            m_kind_q   <= TOK_OBJ_BEGIN;
            m_depth_q  <= '0;
        end else if (clear) begin
            state_q    <= ST_SCAN;
            err_code_q <= ERR_NONE;
            m_valid_q  <= 1'b0;
            m_kind_q   <= TOK_OBJ_BEGIN;
            m_depth_q  <= '0;
        end else begin
            if (accept) begin
                state_q    <= state_d;
                err_code_q <= code_d;
            end
            if (accept && ev_d) begin
                m_valid_q <= 1'b1;
                m_kind_q  <= kind_d;
                m_depth_q <= ev_depth_d;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid  = m_valid_q;
    assign m_kind   = m_kind_q;
    assign m_depth  = m_depth_q;
    assign done     = state_q == ST_DONE;
    assign err      = state_q == ST_ERROR;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_json_struct_scanner.sv
// tb_json_struct_scanner: directed and random JSON streams checked against a queue-based reference
module tb_json_struct_scanner;
    import json_scan_pkg::*;

    localparam int MAXD = 4;
    localparam int DW   = 3;

    typedef logic [7:0] bq_t[$];

    logic          clk, rst_n, clear, s_valid, s_ready, s_last, m_valid, m_ready, done, err;
    logic [7:0]    s_data;
    logic [2:0]    m_kind, err_code;
    logic [DW-1:0] m_depth;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int got[$];
    bit stall_seen = 0;
    logic [2:0]    hold_kind;
    logic [DW-1:0] hold_depth;

    json_struct_scanner #(.MAX_DEPTH(MAXD), .DEPTH_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_kind   (m_kind),
        .m_depth  (m_depth),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ev(input int k, input int d);
        return k * 256 + d;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Event capture plus stall-stability checks, sampled mid-cycle
    always @(negedge clk) begin
        if (stall_seen && m_valid) begin
            chk("hold_kind", m_kind, hold_kind);
            chk("hold_depth", m_depth, hold_depth);
        end
        if (rst_n && m_valid && m_ready) got.push_back(int'(m_kind) * 256 + int'(m_depth));
        if (rst_n && m_valid && !m_ready) begin
            chk("stall_ready", s_ready, 0);
            stall_seen = 1;
            hold_kind  = m_kind;
            hold_depth = m_depth;
        end else begin
            stall_seen = 0;
        end
    end

    // Reference: walks the document with a mode flag and a queue as container stack
    task automatic model(input bq_t d, input bit has_last, output int n, output bit e_done, output int e_code);
        bit stk[$];
        int mode;
        logic [7:0] c;
        int code;
        mode = 0; n = 0; e_done = 0; e_code = 0;
        exp_q.delete();
        for (int i = 0; i < d.size(); i++) begin
            c = d[i];
            code = 0;
            n++;
            if (mode == 0) begin
                if (c == CH_LBRACE || c == CH_LBRACK) begin
                    if (stk.size() == MAXD) code = 1;
                    else begin
                        stk.push_back(c == CH_LBRACK);
                        exp_q.push_back(ev(c == CH_LBRACK ? 2 : 0, stk.size()));
                    end
                end else if (c == CH_RBRACE || c == CH_RBRACK) begin
                    if (stk.size() == 0) code = 2;
                    else if (stk[$] != (c == CH_RBRACK)) code = 3;
                    else begin
                        exp_q.push_back(ev(c == CH_RBRACK ? 3 : 1, stk.size()));
                        void'(stk.pop_back());
                    end
                end else if (c == CH_QUOTE) begin
                    exp_q.push_back(ev(4, stk.size()));
                    mode = 1;
                end else if (c == CH_COLON) exp_q.push_back(ev(6, stk.size()));
                else if (c == CH_COMMA) exp_q.push_back(ev(7, stk.size()));
            end else if (mode == 1) begin
                if (c == CH_BSLASH) mode = 2;
                else if (c == CH_QUOTE) begin
                    exp_q.push_back(ev(5, stk.size()));
                    mode = 0;
                end else if (c < 8'h20) code = 4;
            end else mode = 1;
            if (code == 0 && has_last && i == d.size() - 1) begin
                if (mode == 0 && stk.size() == 0) e_done = 1;
                else code = 5;
            end
            if (code != 0) begin
                e_code = code;
                break;
            end
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1; s_valid = 1; s_data = CH_LBRACE; s_last = 1;
        @(negedge clk);
        chk("clr_ready", s_ready, 0);
        @(posedge clk); #1;
        clear = 0; s_valid = 0; s_last = 0; m_ready = 1;
        @(negedge clk);
        chk("clr_mvalid", m_valid, 0);
        chk("clr_done", done, 0);
        chk("clr_err", err, 0);
        chk("clr_ready_after", s_ready, 1);
        got.delete();
    endtask

    task automatic run_doc(input string name, input bq_t d, input bit has_last, input bit rnd);
        int n, e_code, idx, cyc;
        bit e_done;
        model(d, has_last, n, e_done, e_code);
        got.delete();
        idx = 0; cyc = 0;
        while (idx < n && cyc < 4000) begin
            @(posedge clk); #1;
            m_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            s_valid = rnd ? ($urandom_range(4) != 0) : 1'b1;
            s_data  = d[idx];
            s_last  = has_last && (idx == d.size() - 1);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            cyc++;
        end
        chk({name, "_accepted"}, idx, n);
        @(posedge clk); #1;
        s_valid = 0; s_last = 0; m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, "_nev"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_ev%0d", name, i), i < got.size() ? got[i] : -1, exp_q[i]);
        chk({name, "_done"}, done, e_done);
        chk({name, "_err"}, err, e_code != 0);
        chk({name, "_code"}, err_code, e_code);
        if (e_done || e_code != 0) chk({name, "_ready_end"}, s_ready, 0);
    endtask

    task automatic gen_doc(output bq_t d, output bit has_last);
        bit st[$];
        bit a;
        int len;
        logic [7:0] inner[4];
        logic [7:0] bad[5];
        inner = '{8'h61, CH_RBRACK, CH_LBRACE, CH_COMMA};
        bad   = '{CH_RBRACE, CH_RBRACK, 8'h0A, CH_QUOTE, CH_LBRACK};
        len = $urandom_range(1, 20);
        d.delete();
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(7))
                0, 1: if (st.size() < MAXD + 1) begin
                    a = 1'($urandom_range(1));
                    st.push_back(a);
                    d.push_back(a ? CH_LBRACK : CH_LBRACE);
                end
                2: if (st.size() != 0) begin
                    d.push_back(st[$] ? CH_RBRACK : CH_RBRACE);
                    void'(st.pop_back());
                end
                3: begin
                    d.push_back(CH_QUOTE);
                    repeat ($urandom_range(3)) begin
                        if ($urandom_range(3) == 0) begin
                            d.push_back(CH_BSLASH);
                            d.push_back($urandom_range(1) ? CH_QUOTE : inner[$urandom_range(3)]);
                        end else d.push_back(inner[$urandom_range(3)]);
                    end
                    d.push_back(CH_QUOTE);
                end
                4: d.push_back(CH_COLON);
                5: d.push_back(CH_COMMA);
                6: d.push_back(CH_SPACE);
                default: d.push_back(8'h31);
            endcase
        end
        if ($urandom_range(3) != 0)
            while (st.size() != 0) begin
                d.push_back(st[$] ? CH_RBRACK : CH_RBRACE);
                void'(st.pop_back());
            end
        if (d.size() == 0) d.push_back(CH_SPACE);
        if ($urandom_range(4) == 0) d[$urandom_range(d.size() - 1)] = bad[$urandom_range(4)];
        has_last = $urandom_range(5) != 0;
    endtask

    initial begin
        bq_t d;
        bit hl;
        rst_n = 0; clear = 0; s_valid = 0; s_data = 8'h00; s_last = 0; m_ready = 1;
        #12;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_kind", m_kind, 0);
        chk("rst_m_depth", m_depth, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1;

        run_doc("obj", s2q("{\"a\":[1,2]}"), 1, 0);
        do_clear();
        run_doc("mismatch", s2q("[}"), 1, 0);
        do_clear();
        run_doc("escaped", s2q("[\"a\\\"]\"]"), 1, 0);
        do_clear();
        run_doc("overflow", s2q("[[[[["), 0, 0);
        do_clear();
        run_doc("unterm", s2q("{"), 1, 0);
        do_clear();
        run_doc("ctrl", s2q("\"\n"), 0, 0);
        do_clear();

        // Stall the token register behind an open bracket, then finish the document
        @(posedge clk); #1;
        s_valid = 1; s_data = CH_LBRACK; s_last = 0; m_ready = 0;
        @(posedge clk); #1;
        s_data = CH_RBRACK; s_last = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_s_ready", s_ready, 0);
            chk("stall_kind", m_kind, TOK_ARR_BEGIN);
            chk("stall_depth", m_depth, 1);
            @(posedge clk); #1;
        end
        m_ready = 1;
        @(negedge clk);
        chk("unstall_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 0; s_last = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_nev", got.size(), 2);
        chk("bp_ev0", got.size() > 0 ? got[0] : -1, ev(2, 1));
        chk("bp_ev1", got.size() > 1 ? got[1] : -1, ev(3, 1));
        chk("bp_done", done, 1);
        do_clear();

        // A pending, unconsumed token is discarded by clear
        @(posedge clk); #1;
        s_valid = 1; s_data = CH_LBRACE; s_last = 0; m_ready = 0;
        @(posedge clk); #1;
        s_valid = 0;
        @(negedge clk);
        chk("pend_valid", m_valid, 1);
        @(posedge clk); #1;
        clear = 1;
        @(posedge clk); #1;
        clear = 0; m_ready = 1;
        @(negedge clk);
        chk("pend_dropped", m_valid, 0);
        chk("pend_nev", got.size(), 0);

        // Clear in the middle of a string: the next quote opens a string at depth 0
        run_doc("midstr", s2q("[\"ab"), 0, 0);
        do_clear();
        run_doc("after_clr", s2q("\"x\""), 1, 0);

        for (int k = 0; k < 40; k++) begin
            do_clear();
            gen_doc(d, hl);
            run_doc($sformatf("rnd%0d", k), d, hl, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
